// File: rtl/tl_tx_arbiter.sv
// Posted / non-posted TLP transmit arbiter: credit-gated, round-robin on ties,
// streams a header beat followed (for posted requests) by payload beats.
module tl_tx_arbiter #(
    parameter int TX_DEPTH_LG2 = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    p_hdr_empty_i,
    input  logic [127:0]            p_hdr_rdata_i,
    output logic                    p_hdr_rden_o,
    input  logic                    p_data_empty_i,
    input  logic [255:0]            p_data_rdata_i,
    output logic                    p_data_rden_o,
    input  logic [TX_DEPTH_LG2-1:0] p_payload_cnt_i,
    output logic                    p_sent_o,
    input  logic                    np_hdr_empty_i,
    input  logic [127:0]            np_hdr_rdata_i,
    output logic                    np_hdr_rden_o,
    input  logic [7:0]              ph_limit_i,
    input  logic [11:0]             pd_limit_i,
    input  logic [7:0]              nph_limit_i,
    input  logic                    ph_inf_i,
    input  logic                    pd_inf_i,
    input  logic                    nph_inf_i,
    output logic [255:0]            tlp_data_o,
    output logic                    tlp_valid_o,
    output logic                    tlp_sop_o,
    output logic                    tlp_eop_o,
    input  logic                    tlp_ready_i
);

    typedef enum logic [1:0] {IDLE, HDR, PDATA} state_t;

    // Header length field: length[9:8] in byte 2 and length[7:0] in byte 3
    // of DW0, with DW0 packed in the top 32 bits of the header.
    localparam int LEN_MSB = 105;
    localparam int LEN_LSB = 96;

    function automatic logic [10:0] len_dw(input logic [9:0] len);
        return (len == 10'd0) ? 11'd1024 : {1'b0, len};
    endfunction

    function automatic logic [11:0] pd_need(input logic [9:0] len);
        logic [11:0] t;
        t = {1'b0, len_dw(len)} + 12'd3;
        return {2'b00, t[11:2]};
    endfunction

    function automatic logic [6:0] beats_m1(input logic [9:0] len);
        logic [11:0] t;
        logic [8:0]  b;
        t = {1'b0, len_dw(len)} + 12'd7;
        b = t[11:3] - 9'd1;
        return b[6:0];
    endfunction

    // Modular window compare lets the consumed counters wrap freely.
    function automatic logic credit_ok8(input logic [7:0] limit, input logic [7:0] cons,
                                        input logic [7:0] need);
        logic [7:0] d;
        d = limit - (cons + need);
        return d <= 8'd128;
    endfunction

    function automatic logic credit_ok12(input logic [11:0] limit, input logic [11:0] cons,
                                         input logic [11:0] need);
        logic [11:0] d;
        d = limit - (cons + need);
        return d <= 12'd2048;
    endfunction

    state_t       state_q, state_d;
    logic         grant_np_q, grant_np_d;
    logic         last_np_q, last_np_d;
    logic [6:0]   beat_cnt_q, beat_cnt_d;
    logic [7:0]   ph_cons_q, ph_cons_d;
    logic [7:0]   nph_cons_q, nph_cons_d;
    logic [11:0]  pd_cons_q, pd_cons_d;
    logic [127:0] hdr_q, hdr_d;

    logic [9:0]   p_len;
    logic [11:0]  p_need;
    logic         p_elig;
    logic         np_elig;
    logic         pick_np;

    always_comb begin
        p_len   = p_hdr_rdata_i[LEN_MSB:LEN_LSB];
        p_need  = pd_need(p_len);
        p_elig  = !p_hdr_empty_i && (p_payload_cnt_i != '0)
                  && (ph_inf_i || credit_ok8(ph_limit_i, ph_cons_q, 8'd1))
                  && (pd_inf_i || credit_ok12(pd_limit_i, pd_cons_q, p_need));
        np_elig = !np_hdr_empty_i
                  && (nph_inf_i || credit_ok8(nph_limit_i, nph_cons_q, 8'd1));
        pick_np = np_elig && (!p_elig || !last_np_q);
    end

    always_comb begin
        state_d       = state_q;
        grant_np_d    = grant_np_q;
        last_np_d     = last_np_q;
        beat_cnt_d    = beat_cnt_q;
        ph_cons_d     = ph_cons_q;
        nph_cons_d    = nph_cons_q;
        pd_cons_d     = pd_cons_q;
        hdr_d         = hdr_q;
        tlp_data_o    = '0;
        tlp_valid_o   = 1'b0;
        tlp_sop_o     = 1'b0;
        tlp_eop_o     = 1'b0;
        p_hdr_rden_o  = 1'b0;
        np_hdr_rden_o = 1'b0;
        p_data_rden_o = 1'b0;
        p_sent_o      = 1'b0;

        case (state_q)
            IDLE: begin
                if (p_elig || np_elig) begin
                    state_d    = HDR;
                    grant_np_d = pick_np;
                    last_np_d  = pick_np;
                    if (pick_np) begin
                        hdr_d      = np_hdr_rdata_i;
                        nph_cons_d = nph_cons_q + 8'd1;
                    end else begin
                        hdr_d     = p_hdr_rdata_i;
                        ph_cons_d = ph_cons_q + 8'd1;
                        pd_cons_d = pd_cons_q + p_need;
                    end
                end
            end
            HDR: begin
                tlp_valid_o = 1'b1;
                tlp_sop_o   = 1'b1;
                tlp_eop_o   = grant_np_q;
                tlp_data_o  = {128'b0, hdr_q};
                if (tlp_ready_i) begin
                    if (grant_np_q) begin
                        np_hdr_rden_o = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        p_hdr_rden_o = 1'b1;
                        beat_cnt_d   = beats_m1(hdr_q[LEN_MSB:LEN_LSB]);
                        state_d      = PDATA;
                    end
                end
            end
            PDATA: begin
                // An empty data FIFO mid-packet is just a bubble.
                tlp_valid_o = !p_data_empty_i;
                tlp_data_o  = p_data_rdata_i;
                tlp_eop_o   = (beat_cnt_q == 7'd0);
                if (tlp_valid_o && tlp_ready_i) begin
                    p_data_rden_o = 1'b1;
                    if (tlp_eop_o) begin
                        p_sent_o = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 7'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_np_q <= 1'b0;
            last_np_q  <= 1'b1;
            beat_cnt_q <= '0;
            ph_cons_q  <= '0;
            nph_cons_q <= '0;
            pd_cons_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_np_q <= grant_np_d;
            last_np_q  <= last_np_d;
            beat_cnt_q <= beat_cnt_d;
            ph_cons_q  <= ph_cons_d;
            nph_cons_q <= nph_cons_d;
            pd_cons_q  <= pd_cons_d;
        end
    end

    // Header holding register is only observed outside IDLE, so it needs no reset.
    always_ff @(posedge clk) begin
        hdr_q <= hdr_d;
    end

endmodule

// File: tb/tb_tl_tx_arbiter.sv
// Directed bench for tl_tx_arbiter with a small FIFO stand-in around the DUT.
module tb_tl_tx_arbiter;

    typedef logic [255:0] cv_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         p_hdr_empty_i, p_hdr_rden_o;
    logic [127:0] p_hdr_rdata_i;
    logic         p_data_empty_i, p_data_rden_o;
    logic [255:0] p_data_rdata_i;
    logic [2:0]   p_payload_cnt;
    logic         p_sent_o;
    logic         np_hdr_empty_i, np_hdr_rden_o;
    logic [127:0] np_hdr_rdata_i;
    logic [7:0]   ph_limit, nph_limit;
    logic [11:0]  pd_limit;
    logic         ph_inf, pd_inf, nph_inf;
    logic [255:0] tlp_data_o;
    logic         tlp_valid_o, tlp_sop_o, tlp_eop_o;
    logic         tlp_ready;
    logic         data_stall;

    int n_total = 0;
    int n_bad   = 0;

    int np_pushed = 0, np_popped = 0;
    int p_pushed  = 0, p_popped  = 0;
    int d_popped  = 0, sent_cnt  = 0;
    logic [9:0] p_len [32];
    bit grants[$];

    always #5 clk = ~clk;

    function automatic logic [127:0] mk_phdr(input logic [9:0] len);
        logic [127:0] h;
        h = '0;
        h[127:120] = 8'h60;
        h[105:96]  = len;
        h[31:0]    = 32'h0BAD_F00D;
        return h;
    endfunction

    function automatic logic [127:0] np_hdr(input int k);
        return {96'hA5A5_A5A5_0000_0000_0000_0000, 32'(k)};
    endfunction

    function automatic logic [255:0] mk_data(input int n);
        return {8{32'hD000_0000 + 32'(n)}};
    endfunction

    assign np_hdr_empty_i = (np_pushed == np_popped);
    assign np_hdr_rdata_i = np_hdr(np_popped);
    assign p_hdr_empty_i  = (p_pushed == p_popped);
    assign p_hdr_rdata_i  = mk_phdr(p_len[p_popped % 32]);
    assign p_data_empty_i = data_stall;
    assign p_data_rdata_i = mk_data(d_popped);

    always @(posedge clk) begin
        if (np_hdr_rden_o) np_popped <= np_popped + 1;
        if (p_hdr_rden_o)  p_popped  <= p_popped + 1;
        if (p_data_rden_o) d_popped  <= d_popped + 1;
        if (p_sent_o)      sent_cnt  <= sent_cnt + 1;
        if (tlp_valid_o && tlp_ready && tlp_sop_o) grants.push_back(tlp_eop_o);
    end

    tl_tx_arbiter #(.TX_DEPTH_LG2(3)) dut (
        .clk(clk), .rst(rst),
        .p_hdr_empty_i(p_hdr_empty_i), .p_hdr_rdata_i(p_hdr_rdata_i), .p_hdr_rden_o(p_hdr_rden_o),
        .p_data_empty_i(p_data_empty_i), .p_data_rdata_i(p_data_rdata_i), .p_data_rden_o(p_data_rden_o),
        .p_payload_cnt_i(p_payload_cnt), .p_sent_o(p_sent_o),
        .np_hdr_empty_i(np_hdr_empty_i), .np_hdr_rdata_i(np_hdr_rdata_i), .np_hdr_rden_o(np_hdr_rden_o),
        .ph_limit_i(ph_limit), .pd_limit_i(pd_limit), .nph_limit_i(nph_limit),
        .ph_inf_i(ph_inf), .pd_inf_i(pd_inf), .nph_inf_i(nph_inf),
        .tlp_data_o(tlp_data_o), .tlp_valid_o(tlp_valid_o), .tlp_sop_o(tlp_sop_o),
        .tlp_eop_o(tlp_eop_o), .tlp_ready_i(tlp_ready)
    );

    task automatic check(input string tag, input cv_t got, input cv_t exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    task automatic push_p(input logic [9:0] len);
        p_len[p_pushed % 32] = len;
        p_pushed++;
    endtask

    task automatic wait_sent(input int target, input int budget, input string tag);
        int n = 0;
        while (sent_cnt < target && n < budget) begin
            nxt();
            n++;
        end
        check(tag, cv_t'(sent_cnt), cv_t'(target));
    endtask

    task automatic wait_dpop(input int target, input int budget, input string tag);
        int n = 0;
        while (d_popped < target && n < budget) begin
            nxt();
            n++;
        end
        check(tag, cv_t'(d_popped), cv_t'(target));
    endtask

    task automatic chk_idle_outputs(input string tag);
        check({tag, "_valid"}, cv_t'(tlp_valid_o), cv_t'(0));
        check({tag, "_sop"},   cv_t'(tlp_sop_o),   cv_t'(0));
        check({tag, "_eop"},   cv_t'(tlp_eop_o),   cv_t'(0));
        check({tag, "_data"},  cv_t'(tlp_data_o),  cv_t'(0));
        check({tag, "_pops"},  cv_t'({p_hdr_rden_o, p_data_rden_o, np_hdr_rden_o}), cv_t'(0));
        check({tag, "_sent"},  cv_t'(p_sent_o),    cv_t'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, s0, hp, g0, stalls, n;
        logic stalled, done, ps, pe;
        cv_t pd;

        rst = 1'b1;
        tlp_ready = 1'b1;
        data_stall = 1'b0;
        p_payload_cnt = 3'd0;
        ph_limit = 8'd0; pd_limit = 12'd0; nph_limit = 8'd0;
        ph_inf = 1'b0; pd_inf = 1'b0; nph_inf = 1'b0;
        for (int i = 0; i < 32; i++) p_len[i] = 10'd0;

        // reset state
        nxt(); nxt();
        smp();
        chk_idle_outputs("rst");
        nxt();
        rst = 1'b0;

        // NP only, credit limited to two headers
        nph_limit = 8'd2;
        np_pushed = 3;
        smp();
        check("np_grant_cycle_valid", cv_t'(tlp_valid_o), cv_t'(0));
        nxt(); smp();
        check("np1_valid", cv_t'(tlp_valid_o), cv_t'(1));
        check("np1_sop",   cv_t'(tlp_sop_o),   cv_t'(1));
        check("np1_eop",   cv_t'(tlp_eop_o),   cv_t'(1));
        check("np1_data",  cv_t'(tlp_data_o),  cv_t'({128'b0, np_hdr(0)}));
        check("np1_rden",  cv_t'(np_hdr_rden_o), cv_t'(1));
        nxt(); smp();
        check("np_gap_valid", cv_t'(tlp_valid_o), cv_t'(0));
        nxt(); smp();
        check("np2_valid", cv_t'(tlp_valid_o), cv_t'(1));
        check("np2_data",  cv_t'(tlp_data_o),  cv_t'({128'b0, np_hdr(1)}));
        check("np2_rden",  cv_t'(np_hdr_rden_o), cv_t'(1));
        repeat (6) nxt();
        smp();
        check("np_blocked_pops",  cv_t'(np_popped), cv_t'(2));
        check("np_blocked_valid", cv_t'(tlp_valid_o), cv_t'(0));
        nxt();
        nph_limit = 8'd3;
        repeat (4) nxt();
        smp();
        check("np_after_limit_pops", cv_t'(np_popped), cv_t'(3));
        nxt();

        // P with L=32, PD limit 8; payload count 0 must hold it off
        do_reset();
        ph_inf = 1'b1;
        pd_limit = 12'd8;
        hp = p_popped;
        push_p(10'd32);
        repeat (3) nxt();
        smp();
        check("p_no_payload_pops",  cv_t'(p_popped), cv_t'(hp));
        check("p_no_payload_valid", cv_t'(tlp_valid_o), cv_t'(0));
        nxt();
        p_payload_cnt = 3'd1;
        d0 = d_popped;
        smp();
        check("p_grant_cycle_valid", cv_t'(tlp_valid_o), cv_t'(0));
        nxt(); smp();
        check("p_hdr_valid", cv_t'(tlp_valid_o), cv_t'(1));
        check("p_hdr_sop",   cv_t'(tlp_sop_o),   cv_t'(1));
        check("p_hdr_eop",   cv_t'(tlp_eop_o),   cv_t'(0));
        check("p_hdr_data",  cv_t'(tlp_data_o),  cv_t'({128'b0, mk_phdr(10'd32)}));
        check("p_hdr_rden",  cv_t'(p_hdr_rden_o), cv_t'(1));
        for (int b = 0; b < 4; b++) begin
            nxt(); smp();
            check($sformatf("p_beat%0d_valid", b), cv_t'(tlp_valid_o), cv_t'(1));
            check($sformatf("p_beat%0d_sop", b),   cv_t'(tlp_sop_o),   cv_t'(0));
            check($sformatf("p_beat%0d_eop", b),   cv_t'(tlp_eop_o),   cv_t'(b == 3));
            check($sformatf("p_beat%0d_data", b),  cv_t'(tlp_data_o),  cv_t'(mk_data(d0 + b)));
            check($sformatf("p_beat%0d_rden", b),  cv_t'(p_data_rden_o), cv_t'(1));
            check($sformatf("p_beat%0d_sent", b),  cv_t'(p_sent_o),    cv_t'(b == 3));
        end
        nxt(); smp();
        check("p_after_eop_valid", cv_t'(tlp_valid_o), cv_t'(0));
        nxt();

        // second L=32 needs pd_limit >= 16
        push_p(10'd32);
        repeat (6) nxt();
        smp();
        check("p2_blocked_pops",  cv_t'(p_popped), cv_t'(hp + 1));
        check("p2_blocked_valid", cv_t'(tlp_valid_o), cv_t'(0));
        nxt();
        pd_limit = 12'd15;
        repeat (3) nxt();
        smp();
        check("p2_limit15_pops", cv_t'(p_popped), cv_t'(hp + 1));
        nxt();
        pd_limit = 12'd16;
        d0 = d_popped;
        s0 = sent_cnt;
        stalled = 1'b0; done = 1'b0; stalls = 0;
        ps = 1'b0; pe = 1'b0; pd = '0;
        for (int c = 0; c < 60 && !done; c++) begin
            tlp_ready = c[0];
            smp();
            if (stalled) begin
                check("stall_hold_valid", cv_t'(tlp_valid_o), cv_t'(1));
                check("stall_hold_data",  cv_t'(tlp_data_o),  pd);
                check("stall_hold_sop",   cv_t'(tlp_sop_o),   cv_t'(ps));
                check("stall_hold_eop",   cv_t'(tlp_eop_o),   cv_t'(pe));
            end
            if (tlp_valid_o && !tlp_ready) begin
                check("stall_no_pop", cv_t'({p_hdr_rden_o, p_data_rden_o, np_hdr_rden_o}), cv_t'(0));
                stalled = 1'b1;
                stalls++;
                pd = tlp_data_o; ps = tlp_sop_o; pe = tlp_eop_o;
            end else begin
                stalled = 1'b0;
            end
            if (p_sent_o) done = 1'b1;
            nxt();
        end
        tlp_ready = 1'b1;
        check("toggle_done",   cv_t'(done), cv_t'(1));
        check("toggle_stalls", cv_t'(stalls), cv_t'(4));
        check("toggle_dpops",  cv_t'(d_popped - d0), cv_t'(4));
        check("toggle_sent",   cv_t'(sent_cnt - s0), cv_t'(1));

        // both classes eligible: P, NP, P, NP, P, NP
        do_reset();
        ph_inf = 1'b1; pd_inf = 1'b1; nph_inf = 1'b1;
        g0 = grants.size();
        for (int i = 0; i < 3; i++) push_p(10'd8);
        np_pushed = np_pushed + 3;
        n = 0;
        while (grants.size() < g0 + 6 && n < 100) begin
            nxt();
            n++;
        end
        check("rr_grant_count", cv_t'(grants.size() - g0), cv_t'(6));
        for (int i = 0; i < 6; i++) begin
            if (g0 + i < grants.size())
                check($sformatf("rr_grant%0d_is_np", i), cv_t'(grants[g0 + i]), cv_t'(i % 2));
        end
        wait_sent(sent_cnt + (p_pushed - p_popped), 20, "rr_drain");

        // L=0 packets: 128 beats each, then consumed wraps to 0xFFC
        do_reset();
        ph_inf = 1'b1; pd_inf = 1'b1; nph_inf = 1'b0;
        d0 = d_popped;
        s0 = sent_cnt;
        for (int i = 0; i < 15; i++) push_p(10'd0);
        push_p(10'd1008);
        wait_dpop(d0 + 10, 40, "l0_reach_beat10");
        data_stall = 1'b1;
        smp();
        check("empty_stall_valid", cv_t'(tlp_valid_o), cv_t'(0));
        check("empty_stall_rden",  cv_t'(p_data_rden_o), cv_t'(0));
        repeat (3) nxt();
        smp();
        check("empty_stall_pops", cv_t'(d_popped - d0), cv_t'(10));
        nxt();
        data_stall = 1'b0;
        wait_sent(s0 + 1, 300, "l0_first_sent");
        check("l0_beats", cv_t'(d_popped - d0), cv_t'(128));
        wait_sent(s0 + 16, 2500, "fill_sent");
        check("fill_beats", cv_t'(d_popped - d0), cv_t'(15 * 128 + 126));
        pd_inf = 1'b0;
        pd_limit = 12'd3;
        hp = p_popped;
        push_p(10'd32);
        repeat (6) nxt();
        smp();
        check("wrap_limit3_pops", cv_t'(p_popped), cv_t'(hp));
        nxt();
        pd_limit = 12'h004;
        wait_sent(s0 + 17, 20, "wrap_limit4_sent");

        // reset on data beat 2 of 4
        do_reset();
        ph_inf = 1'b1; pd_inf = 1'b0; pd_limit = 12'd8;
        d0 = d_popped;
        hp = p_popped;
        push_p(10'd32);
        wait_dpop(d0 + 1, 10, "mid_reach_beat2");
        rst = 1'b1;
        #1;
        chk_idle_outputs("mid_rst");
        nxt(); smp();
        check("mid_rst_no_pops", cv_t'(d_popped - d0), cv_t'(1));
        nxt();
        rst = 1'b0;
        s0 = sent_cnt;
        push_p(10'd32);
        wait_sent(s0 + 1, 20, "post_rst_sent");
        check("post_rst_dpops", cv_t'(d_popped - d0), cv_t'(5));
        check("post_rst_hpops", cv_t'(p_popped - hp), cv_t'(2));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tl_tx_arbiter.md
TL_TX_ARBITER -- requirements
Module: tl_tx_arbiter

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter TX_DEPTH_LG2, default 3, width of the P payload count input.
REQ-003 SHALL have ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- p_hdr_empty_i  in  1  P header FIFO empty
- p_hdr_rdata_i  in  128  P header, PCIE_PKG::tlp_memory_req_hdr_t, valid while non-empty
- p_hdr_rden_o  out  1  P header pop
- p_data_empty_i  in  1  P data FIFO empty
- p_data_rdata_i  in  256  P data beat
- p_data_rden_o  out  1  P data pop
- p_payload_cnt_i  in  TX_DEPTH_LG2  complete P payloads buffered
- p_sent_o  out  1  one-cycle pulse per P TLP fully sent
- np_hdr_empty_i  in  1  NP header FIFO empty
- np_hdr_rdata_i  in  128  NP header
- np_hdr_rden_o  out  1  NP header pop
- ph_limit_i  in  8  PH credit limit
- pd_limit_i  in  12  PD credit limit
- nph_limit_i  in  8  NPH credit limit
- ph_inf_i, pd_inf_i, nph_inf_i  in  1 each  class has infinite credit
- tlp_data_o  out  256  TLP beat
- tlp_valid_o  out  1  beat valid
- tlp_sop_o  out  1  first beat of TLP
- tlp_eop_o  out  1  last beat of TLP
- tlp_ready_i  in  1  downstream accept

Function
REQ-004 SHALL implement states IDLE, HDR, PDATA.
REQ-005 Eligibility in IDLE SHALL be computed combinationally.
- P eligible: !p_hdr_empty_i and p_payload_cnt_i != 0 and PH credit ok for 1 and PD credit ok for need.
- NP eligible: !np_hdr_empty_i and NPH credit ok for 1.
REQ-006 The P length L SHALL be {length_h,length_l} of p_hdr_rdata_i, with L=0 meaning 1024 DW.
- PD credits needed = ceil(L/4).
- Data beats = ceil(L/8), range 1..128.
REQ-007 Credit check SHALL be satisfied when the class infinite flag is 1.
- Otherwise it SHALL be satisfied when (limit - (consumed + need)) mod 2^N <= 2^(N-1).
- N = 8 for PH/NPH and 12 for PD; consumed counters are internal and wrap modulo 2^N.
REQ-008 When only one class is eligible in IDLE, it SHALL be granted.
REQ-009 When both classes are eligible, grant SHALL be round-robin: the class not granted last wins.
- Last-grant register resets to NP, so P wins the first tie.
REQ-010 On grant, the arbiter SHALL register the grant and go to HDR the next cycle.
- The consumed counters for that class SHALL advance by need in the same clock.
REQ-011 In HDR, tlp_valid_o=1 and tlp_sop_o=1.
- tlp_data_o = {128'b0, granted header}.
- tlp_eop_o = 1 for NP, 0 for P.
REQ-012 On tlp_valid_o & tlp_ready_i in HDR, the granted header rden SHALL pulse for 1 cycle.
- NP: go to IDLE.
- P: load the beat counter with beats-1 and go to PDATA.
REQ-013 In PDATA:
- tlp_valid_o = !p_data_empty_i; tlp_data_o = p_data_rdata_i.
- tlp_eop_o = 1 when the beat counter = 0.
- p_data_rden_o = tlp_valid_o & tlp_ready_i.
- The counter decrements per accepted beat.
REQ-014 On acceptance of the eop beat in PDATA, p_sent_o SHALL pulse 1 cycle and the state SHALL return to IDLE.
REQ-015 While tlp_valid_o=1 and tlp_ready_i=0, tlp_data/sop/eop SHALL hold stable and no FIFO pop SHALL occur.
REQ-016 Outputs SHALL be 0 in IDLE; the minimum gap between TLPs is 1 idle cycle.
- Eligible to tlp_valid_o latency is 1 cycle.
REQ-017 A limit input change SHALL take effect in the same-cycle eligibility check.
- A limit change in the grant cycle SHALL NOT alter the consumed update.
REQ-018 p_data_empty_i mid-packet SHALL stall with tlp_valid_o=0; it SHALL NOT be treated as an error.

Reset
REQ-019 On rst=1, the block SHALL go asynchronously to IDLE.
- Consumed counters, beat counter and last-grant register (NP) SHALL reset.
- All outputs SHALL be 0.
REQ-020 Reset mid-packet SHALL abandon the TLP with no further pops; FIFO recovery is the upstream reset's responsibility.

Verification
REQ-021 NP only, nph_limit=2, 3 headers queued, ready=1 -> 2 single-beat TLPs (sop=eop=1), 2 np_hdr_rden pulses, then stall until nph_limit=3.
REQ-022 P with L=32, payload_cnt=1, pd_limit=8, ready=1 -> header beat, then 4 data beats, eop on 4th, p_sent pulse; a second L=32 P blocks until pd_limit>=16.
REQ-023 P and NP both eligible continuously -> grants alternate P,NP,P,NP starting with P.
REQ-024 ready toggling 1/0 during PDATA -> data stable while stalled, exactly 4 p_data_rden pulses for L=32.
REQ-025 L=0 header -> PD need 256, 128 data beats; consumed wrap: pd_limit=0x004 with consumed=0xFFC and need 8 -> eligible.
REQ-026 rst asserted on data beat 2 of 4 -> all outputs 0 immediately; after release, next grant starts in IDLE with counters zeroed.
